// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: walks the mepc/mcause/mstatus CSR write sequence
// for ebreak, ecall, interrupts and mret, then issues a fetch redirect.
module trap_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_req,
  input  logic [2:0]      trap_kind,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            irq_ext,
  input  logic            irq_soft,
  input  logic            irq_timer,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mie_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  output logic            busy,
  output logic            csr_wt_en,
  output logic [11:0]     csr_wt_idx,
  output logic [XLEN-1:0] csr_wt_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_EPC    = 3'd1,
    W_CAUSE  = 3'd2,
    W_STATUS = 3'd3,
    REDIRECT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [3:0]        code_q, code_d;
  logic              irq_q, irq_d;
  logic              mret_q, mret_d;

  logic              busy_q, busy_d;
  logic              wt_en_q, wt_en_d;
  logic [11:0]       wt_idx_q, wt_idx_d;
  logic [XLEN-1:0]   wt_data_q, wt_data_d;
  logic              rv_q, rv_d;
  logic [XLEN-1:0]   rpc_q, rpc_d;
  logic              done_q, done_d;

  logic              irq_take;
  logic [3:0]        irq_code;
  logic [XLEN-1:0]   status_v;
  logic              unused_mie;

  assign unused_mie = ^mie_in;

  // Fixed-priority interrupt pick: external > software > timer.
  always_comb begin
    irq_take = mstatus_in[3] && ((irq_ext && mie_in[11]) || (irq_soft && mie_in[3]) ||
                                 (irq_timer && mie_in[7]));
    if (irq_ext && mie_in[11]) begin
      irq_code = 4'd11;
    end else if (irq_soft && mie_in[3]) begin
      irq_code = 4'd3;
    end else begin
      irq_code = 4'd7;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    code_d  = code_q;
    irq_d   = irq_q;
    mret_d  = mret_q;
    case (state_q)
      IDLE: begin
        if (trap_req) begin
          case (trap_kind)
            3'b001: begin
              state_d = W_EPC; pc_d = trap_pc; code_d = 4'd3;  irq_d = 1'b0; mret_d = 1'b0;
            end
            3'b010: begin
              state_d = W_EPC; pc_d = trap_pc; code_d = 4'd11; irq_d = 1'b0; mret_d = 1'b0;
            end
            3'b100: begin
              state_d = W_STATUS; irq_d = 1'b0; mret_d = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end else if (irq_take) begin
          state_d = W_EPC; pc_d = trap_pc; code_d = irq_code; irq_d = 1'b1; mret_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      W_EPC:    state_d = W_CAUSE;
      W_CAUSE:  state_d = W_STATUS;
      W_STATUS: state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they register alongside it.
  always_comb begin
    status_v = mstatus_in;
    if (mret_d) begin
      status_v[3] = mstatus_in[7];
      status_v[7] = 1'b1;
    end else begin
      status_v[7]     = mstatus_in[3];
      status_v[3]     = 1'b0;
      status_v[12:11] = 2'b11;
    end

    busy_d    = (state_d != IDLE);
    wt_en_d   = 1'b0;
    wt_idx_d  = 12'h000;
    wt_data_d = '0;
    rv_d      = 1'b0;
    rpc_d     = '0;
    done_d    = 1'b0;
    case (state_d)
      W_EPC: begin
        wt_en_d = 1'b1; wt_idx_d = 12'h341; wt_data_d = pc_d;
      end
      W_CAUSE: begin
        wt_en_d  = 1'b1;
        wt_idx_d = 12'h342;
        wt_data_d = irq_d ? {1'b1, (XLEN-1)'(code_d)} : XLEN'(code_d);
      end
      W_STATUS: begin
        wt_en_d = 1'b1; wt_idx_d = 12'h300; wt_data_d = status_v;
      end
      REDIRECT: begin
        rv_d   = 1'b1;
        done_d = 1'b1;
        if (mret_d) begin
          rpc_d = mepc_in;
        end else if (irq_d && (mtvec_in[1:0] == 2'b01)) begin
          rpc_d = {mtvec_in[XLEN-1:2], 2'b00} + XLEN'({code_d, 2'b00});
        end else begin
          rpc_d = {mtvec_in[XLEN-1:2], 2'b00};
        end
      end
      default: begin
        wt_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      code_q    <= 4'd0;
      irq_q     <= 1'b0;
      mret_q    <= 1'b0;
      busy_q    <= 1'b0;
      wt_en_q   <= 1'b0;
      wt_idx_q  <= 12'h000;
      wt_data_q <= '0;
      rv_q      <= 1'b0;
      rpc_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      code_q    <= code_d;
      irq_q     <= irq_d;
      mret_q    <= mret_d;
      busy_q    <= busy_d;
      wt_en_q   <= wt_en_d;
      wt_idx_q  <= wt_idx_d;
      wt_data_q <= wt_data_d;
      rv_q      <= rv_d;
      rpc_q     <= rpc_d;
      done_q    <= done_d;
    end
  end

  assign busy           = busy_q;
  assign csr_wt_en      = wt_en_q;
  assign csr_wt_idx     = wt_idx_q;
  assign csr_wt_data    = wt_data_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign trap_done      = done_q;

endmodule
